// File: rtl/cnn1d_pkg.sv
// Shared types for the cnn1d classifier blocks.
// Holds the argmax FSM state encoding used by cnn1d_argmax.
// No ports; imported with `import cnn1d_pkg::*`.
package cnn1d_pkg;

  // The 2-bit encoding leaves 2'b11 unused; the FSM sends it back to IDLE.
  typedef enum logic [1:0] {
    ARGMAX_IDLE = 2'd0,
    ARGMAX_SCAN = 2'd1,
    ARGMAX_OUT  = 2'd2
  } argmax_state_t;

endpackage

// File: rtl/cnn1d_top2_update.sv
// Purpose: one step of a running top-2 search over signed scores.
// Latency: combinational. Backpressure: none; it is a pure function of its inputs.
// Ports: d_i/idx_i   = candidate score and its class index
//        best_i/best_idx_i/second_i = current top-2 state
//        best_o/best_idx_o/second_o = updated top-2 state
// A candidate equal to the current best never displaces it, so the lowest
// index wins a tie; the equal value still becomes second, giving margin 0.
module cnn1d_top2_update #(
  parameter int DATA_WIDTH  = 32,
  parameter int CLASS_WIDTH = 1
) (
  input  logic [DATA_WIDTH-1:0]  d_i,
  input  logic [CLASS_WIDTH-1:0] idx_i,
  input  logic [DATA_WIDTH-1:0]  best_i,
  input  logic [CLASS_WIDTH-1:0] best_idx_i,
  input  logic [DATA_WIDTH-1:0]  second_i,
  output logic [DATA_WIDTH-1:0]  best_o,
  output logic [CLASS_WIDTH-1:0] best_idx_o,
  output logic [DATA_WIDTH-1:0]  second_o
);

  always_comb begin
    best_o     = best_i;
    best_idx_o = best_idx_i;
    second_o   = second_i;
    if ($signed(d_i) > $signed(best_i)) begin
      second_o   = best_i;
      best_o     = d_i;
      best_idx_o = idx_i;
    end else if ($signed(d_i) > $signed(second_i)) begin
      second_o = d_i;
    end
  end

endmodule

// File: rtl/cnn1d_argmax.sv
// Purpose: argmax classifier head. It captures one vector of NUM_CLASSES signed
//          scores and serially finds the winning class, its score and the
//          saturated top-1/top-2 margin.
// Latency: argmax_valid_out rises NUM_CLASSES-1 cycles after the accept edge.
// Backpressure: the result is held until argmax_ready_out. Only one vector is
//          in flight, so argmax_ready_in stays low from accept until the cycle
//          after the output handshake.
// Ports: clk/rst_n (sync active-low); argmax_valid_in/argmax_data_in/argmax_ready_in
//        = input vector handshake; argmax_valid_out/argmax_ready_out = result
//        handshake; argmax_class/argmax_score/argmax_margin = registered result.
// Optional: define CNN1D_ARGMAX_CONFIDENCE_EN to add parameter CONF_THRESHOLD and
//        output argmax_confident (saturated margin >= CONF_THRESHOLD).
module cnn1d_argmax
  import cnn1d_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int FRACTION    = 24,
  parameter int NUM_CLASSES = 2,
  parameter int CLASS_WIDTH = $clog2(NUM_CLASSES)
`ifdef CNN1D_ARGMAX_CONFIDENCE_EN
  , parameter logic [DATA_WIDTH-1:0] CONF_THRESHOLD = '0
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   argmax_ready_in,
  input  logic [0:NUM_CLASSES-1] argmax_valid_in,
  input  logic [DATA_WIDTH-1:0]  argmax_data_in [0:NUM_CLASSES-1],
  input  logic                   argmax_ready_out,
  output logic                   argmax_valid_out,
  output logic [CLASS_WIDTH-1:0] argmax_class,
  output logic [DATA_WIDTH-1:0]  argmax_score,
  output logic [DATA_WIDTH-1:0]  argmax_margin
`ifdef CNN1D_ARGMAX_CONFIDENCE_EN
  , output logic                 argmax_confident
`endif
);

  // The comparison is scale-independent, so FRACTION only has to be sane.
  if (NUM_CLASSES < 2 || FRACTION < 0 || FRACTION >= DATA_WIDTH) begin : g_bad_params
    $error("cnn1d_argmax: NUM_CLASSES must be >= 2 and FRACTION within DATA_WIDTH");
  end

  localparam logic [CLASS_WIDTH-1:0] LAST_IDX = CLASS_WIDTH'(NUM_CLASSES - 1);
  localparam logic [DATA_WIDTH-1:0]  MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0]  MOST_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  argmax_state_t          state_q, state_d;
  logic [DATA_WIDTH-1:0]  data_q [0:NUM_CLASSES-1];
  logic [CLASS_WIDTH-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0]  best_q, best_d;
  logic [CLASS_WIDTH-1:0] best_idx_q, best_idx_d;
  logic [DATA_WIDTH-1:0]  second_q, second_d;
  logic [CLASS_WIDTH-1:0] class_q, class_d;
  logic [DATA_WIDTH-1:0]  score_q, score_d;
  logic [DATA_WIDTH-1:0]  margin_q, margin_d;
`ifdef CNN1D_ARGMAX_CONFIDENCE_EN
  logic                   conf_q, conf_d;
`endif

  logic                   accept;
  logic [DATA_WIDTH-1:0]  upd_best;
  logic [CLASS_WIDTH-1:0] upd_best_idx;
  logic [DATA_WIDTH-1:0]  upd_second;
  logic [DATA_WIDTH:0]    diff;
  logic [DATA_WIDTH-1:0]  sat_margin;

  assign argmax_ready_in  = (state_q == ARGMAX_IDLE) && rst_n;
  // A partially valid vector is simply not accepted; the producer keeps presenting.
  assign accept           = argmax_ready_in && (&argmax_valid_in);
  assign argmax_valid_out = (state_q == ARGMAX_OUT);
  assign argmax_class     = class_q;
  assign argmax_score     = score_q;
  assign argmax_margin    = margin_q;
`ifdef CNN1D_ARGMAX_CONFIDENCE_EN
  assign argmax_confident = conf_q;
`endif

  cnn1d_top2_update #(
    .DATA_WIDTH (DATA_WIDTH),
    .CLASS_WIDTH(CLASS_WIDTH)
  ) u_top2_update (
    .d_i       (data_q[idx_q]),
    .idx_i     (idx_q),
    .best_i    (best_q),
    .best_idx_i(best_idx_q),
    .second_i  (second_q),
    .best_o    (upd_best),
    .best_idx_o(upd_best_idx),
    .second_o  (upd_second)
  );

  // best >= second always holds, so the sign-extended difference is
  // non-negative; anything past the largest positive score clamps to it.
  assign diff       = {upd_best[DATA_WIDTH-1], upd_best} - {upd_second[DATA_WIDTH-1], upd_second};
  assign sat_margin = (diff[DATA_WIDTH] | diff[DATA_WIDTH-1]) ? MOST_POS : diff[DATA_WIDTH-1:0];

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    second_d   = second_q;
    class_d    = class_q;
    score_d    = score_q;
    margin_d   = margin_q;
`ifdef CNN1D_ARGMAX_CONFIDENCE_EN
    conf_d     = conf_q;
`endif
    case (state_q)
      ARGMAX_IDLE: begin
        if (accept) begin
          best_d     = argmax_data_in[0];
          best_idx_d = '0;
          second_d   = MOST_NEG;
          idx_d      = CLASS_WIDTH'(1);
          state_d    = ARGMAX_SCAN;
        end
      end
      ARGMAX_SCAN: begin
        best_d     = upd_best;
        best_idx_d = upd_best_idx;
        second_d   = upd_second;
        if (idx_q == LAST_IDX) begin
          class_d  = upd_best_idx;
          score_d  = upd_best;
          margin_d = sat_margin;
`ifdef CNN1D_ARGMAX_CONFIDENCE_EN
          conf_d   = (sat_margin >= CONF_THRESHOLD);
`endif
          state_d  = ARGMAX_OUT;
        end else begin
          idx_d = idx_q + CLASS_WIDTH'(1);
        end
      end
      ARGMAX_OUT: begin
        if (argmax_ready_out) begin
          state_d = ARGMAX_IDLE;
        end
      end
      default: state_d = ARGMAX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ARGMAX_IDLE;
      idx_q      <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      second_q   <= '0;
      class_q    <= '0;
      score_q    <= '0;
      margin_q   <= '0;
`ifdef CNN1D_ARGMAX_CONFIDENCE_EN
      conf_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      second_q   <= second_d;
      class_q    <= class_d;
      score_q    <= score_d;
      margin_q   <= margin_d;
`ifdef CNN1D_ARGMAX_CONFIDENCE_EN
      conf_q     <= conf_d;
`endif
    end
  end

  // The score store is only read in SCAN after a capture, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < NUM_CLASSES; i++) begin
        data_q[i] <= argmax_data_in[i];
      end
    end
  end

endmodule
